// File: rtl/interp_requant_pkg.sv
// Shared DSP definitions for the interpolator output path: width helper and round modes.
package interp_requant_pkg;

  typedef enum logic {
    ROUND_TRUNC   = 1'b0,
    ROUND_HALF_UP = 1'b1
  } round_mode_e;

  // Full-precision FIR output width; the interpolator sizes OUTPUT_WIDTH with the same rule.
  function automatic int calc_in_width(input int data_w, input int coeff_w, input int n_coeffs);
    return data_w + coeff_w + $clog2(n_coeffs) + 1;
  endfunction

endpackage

// File: rtl/interp_requant_sat_clip.sv
// sat_clip: combinational signed clip from W_IN to W_OUT bits with a saturation flag.
module sat_clip #(
  parameter int W_IN  = 21,
  parameter int W_OUT = 16
) (
  input  logic [W_IN-1:0]  din,
  output logic [W_OUT-1:0] dout,
  output logic             sat
);

  generate
    if (W_IN > W_OUT) begin : g_clip
      // Value fits only if every bit above the output sign bit matches it.
      logic [W_IN-W_OUT:0] top;
      logic                ovf;
      assign top = din[W_IN-1:W_OUT-1];
      assign ovf = ~((&top) | ~(|top));

      always_comb begin
        dout = din[W_OUT-1:0];
        sat  = ovf;
        if (ovf) dout = din[W_IN-1] ? {1'b1, {(W_OUT-1){1'b0}}} : {1'b0, {(W_OUT-1){1'b1}}};
      end
    end else begin : g_ext
      assign dout = W_OUT'($signed(din));
      assign sat  = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/interp_requant.sv
// Two-stage valid/ready requantizer: rescale (optional round-half-up), then signed saturate.
// Optional INTERP_REQUANT_SAT_CNT_EN adds a saturating 16-bit clip counter port sat_count.
module interp_requant
  import interp_requant_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int N_COEFFS    = 3,
  parameter int IN_WIDTH    = calc_in_width(DATA_WIDTH, COEFF_WIDTH, N_COEFFS),
  parameter int FRAC_BITS   = COEFF_WIDTH - 1
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  round_en,
  input  logic                  sat_clr,
  input  logic [IN_WIDTH-1:0]   src_data_in,
  input  logic                  src_valid_in,
  output logic                  src_ready_out,
  output logic [DATA_WIDTH-1:0] dst_data_out,
  output logic                  dst_valid_out,
  input  logic                  dst_ready_in,
  output logic                  dst_sat_out,
  output logic                  sat_sticky
`ifdef INTERP_REQUANT_SAT_CNT_EN
  ,
  output logic [15:0]           sat_count
`endif
);

  localparam int S1_W = IN_WIDTH + 1 - FRAC_BITS;
  localparam logic [IN_WIDTH:0] RND_HALF = (IN_WIDTH+1)'(1) << (FRAC_BITS - 1);

  logic                  s1_v_q, s2_v_q, s2_sat_q, sticky_q;
  logic [S1_W-1:0]       s1_q, s1_d;
  logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
  logic                  s2_sat_d, sticky_d;
  logic                  s1_en, s2_en;
  logic [IN_WIDTH:0]     t;
  logic                  unused_frac;

  assign s2_en         = ~s2_v_q | dst_ready_in;
  assign s1_en         = ~s1_v_q | s2_en;
  assign src_ready_out = s1_en;

  // One extra bit keeps the rounding add from wrapping; dropping FRAC_BITS LSBs is the >>>.
  assign t           = {src_data_in[IN_WIDTH-1], src_data_in}
                     + ((round_mode_e'(round_en) == ROUND_HALF_UP) ? RND_HALF : '0);
  assign s1_d        = t[IN_WIDTH:FRAC_BITS];
  assign unused_frac = ^t[FRAC_BITS-1:0];

  sat_clip #(.W_IN(S1_W), .W_OUT(DATA_WIDTH)) u_clip (
    .din  (s1_q),
    .dout (s2_data_d),
    .sat  (s2_sat_d)
  );

  // Set wins over clear when a clipped sample lands in stage 2 on the same edge.
  assign sticky_d = (sticky_q & ~sat_clr) | (s2_en & s1_v_q & s2_sat_d);

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      s1_v_q    <= 1'b0;
      s1_q      <= '0;
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
      s2_sat_q  <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      if (s1_en) begin
        s1_v_q <= src_valid_in;
        if (src_valid_in) s1_q <= s1_d;
      end
      if (s2_en) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) begin
          s2_data_q <= s2_data_d;
          s2_sat_q  <= s2_sat_d;
        end
      end
      sticky_q <= sticky_d;
    end
  end

  assign dst_valid_out = s2_v_q;
  assign dst_data_out  = s2_data_q;
  assign dst_sat_out   = s2_sat_q;
  assign sat_sticky    = sticky_q;

`ifdef INTERP_REQUANT_SAT_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        cnt_inc;

  assign cnt_inc = s2_v_q & dst_ready_in & s2_sat_q;

  always_comb begin
    cnt_d = cnt_q;
    if (sat_clr)                          cnt_d = {15'd0, cnt_inc};
    else if (cnt_inc && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!arst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign sat_count = cnt_q;
`endif

endmodule

// File: tb/tb_interp_requant.sv
// Randomized self-checking bench for interp_requant with an arithmetic reference model.
module tb_interp_requant;

  localparam int DW = 16;
  localparam int IW = 35;
  localparam int FB = 15;
  localparam longint ONE  = longint'(1) <<< FB;
  localparam longint HALF = longint'(1) <<< (FB - 1);

  logic          clk = 1'b0;
  logic          arst_n, round_en, sat_clr, src_valid_in, dst_ready_in;
  logic [IW-1:0] src_data_in;
  logic          src_ready_out, dst_valid_out, dst_sat_out, sat_sticky;
  logic [DW-1:0] dst_data_out;
`ifdef INTERP_REQUANT_SAT_CNT_EN
  logic [15:0]   sat_count;
`endif

  interp_requant dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .round_en      (round_en),
    .sat_clr       (sat_clr),
    .src_data_in   (src_data_in),
    .src_valid_in  (src_valid_in),
    .src_ready_out (src_ready_out),
    .dst_data_out  (dst_data_out),
    .dst_valid_out (dst_valid_out),
    .dst_ready_in  (dst_ready_in),
    .dst_sat_out   (dst_sat_out),
    .sat_sticky    (sat_sticky)
`ifdef INTERP_REQUANT_SAT_CNT_EN
    ,
    .sat_count     (sat_count)
`endif
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: floor((x + half) / 2^FB), then clip to the signed output range.
  function automatic void model(input longint x, input bit r, output longint d, output bit s);
    longint t, q;
    t = x + (r ? HALF : 64'sd0);
    q = t / ONE;
    if ((t % ONE) != 0 && t < 0) q = q - 1;
    s = 1'b1;
    if (q > 32767)       d = 32767;
    else if (q < -32768) d = -32768;
    else begin d = q; s = 1'b0; end
  endfunction

  longint exp_d[$];
  bit     exp_s[$];
  longint got[$];
  bit     rst_seen = 1'b0, stall_v = 1'b0, stk_chk = 1'b0, clip_acc = 1'b0, clip_out = 1'b0;
  longint held_d;
  bit     held_s;

  // Compare process: inputs are stable mid-cycle, so handshakes seen here happen on the next edge.
  always @(negedge clk) begin
    longint d, pd;
    bit s, ps;
    if (!arst_n) begin
      exp_d.delete(); exp_s.delete();
      stall_v  = 1'b0;
      rst_seen = 1'b1;
    end else begin
      if (rst_seen) begin
        chk("rst_valid", dst_valid_out, 0);
        chk("rst_data", longint'(dst_data_out), 0);
        chk("rst_sat", dst_sat_out, 0);
        chk("rst_sticky", sat_sticky, 0);
`ifdef INTERP_REQUANT_SAT_CNT_EN
        chk("rst_count", sat_count, 0);
`endif
        rst_seen = 1'b0;
      end
      if (stall_v) begin
        chk("hold_data", longint'($signed(dst_data_out)), held_d);
        chk("hold_sat", dst_sat_out, held_s);
      end
      chk("src_ready", src_ready_out, ((exp_d.size() < 2) || dst_ready_in) ? 1 : 0);
      if (dst_valid_out) chk("occupancy", (exp_d.size() != 0) ? 1 : 0, 1);
      if (dst_valid_out && dst_sat_out) clip_out = 1'b1;
      if (dst_valid_out && dst_ready_in && exp_d.size() != 0) begin
        pd = exp_d.pop_front();
        ps = exp_s.pop_front();
        chk("out_data", longint'($signed(dst_data_out)), pd);
        chk("out_sat", dst_sat_out, ps);
        got.push_back(longint'($signed(dst_data_out)));
      end
      if (src_valid_in && src_ready_out) begin
        model(longint'($signed(src_data_in)), round_en, d, s);
        exp_d.push_back(d);
        exp_s.push_back(s);
        if (s) clip_acc = 1'b1;
      end
      if (stk_chk && clip_out) chk("sticky_set", sat_sticky, 1);
      if (stk_chk && !clip_acc) chk("sticky_clear", sat_sticky, 0);
      stall_v = dst_valid_out && !dst_ready_in;
      held_d  = longint'($signed(dst_data_out));
      held_s  = dst_sat_out;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One isolated sample from an idle pipeline with dst_ready_in=1; checks the 2-cycle latency.
  task automatic send(input string name, input longint x, input bit r, input longint e, input bit es);
    dst_ready_in = 1'b1;
    src_data_in  = IW'(x);
    round_en     = r;
    src_valid_in = 1'b1;
    cyc();
    src_valid_in = 1'b0;
    cyc();
    chk({name, "_valid"}, dst_valid_out, 1);
    chk({name, "_data"}, longint'($signed(dst_data_out)), e);
    chk({name, "_sat"}, dst_sat_out, es);
    cyc();
  endtask

  initial begin
    #400000;
    mismatched++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog");
  end

  initial begin
    longint d, v;
    bit s, acc;
    int i, c;
    bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    arst_n = 1'b0; round_en = 1'b0; sat_clr = 1'b0;
    src_valid_in = 1'b0; src_data_in = '0; dst_ready_in = 1'b1;
    repeat (3) cyc();
    arst_n = 1'b1;

    model(-81920, 1'b1, d, s);                   chk("model_tie_neg", d, -2);
    model(-114688, 1'b0, d, s);                  chk("model_floor", d, -4);
    model(longint'(40000) <<< FB, 1'b0, d, s);   chk("model_clip", d, 32767); chk("model_clip_s", s, 1);

    // Back-to-back at full rate.
    cyc();
    round_en = 1'b1; src_valid_in = 1'b1; src_data_in = IW'(longint'(98304));
    cyc();
    src_data_in = IW'(longint'(114688));
    cyc();
    src_valid_in = 1'b0;
    chk("pt0_valid", dst_valid_out, 1);
    chk("pt0_data", longint'($signed(dst_data_out)), 3);
    cyc();
    chk("pt1_data", longint'($signed(dst_data_out)), 4);
    chk("pt1_sat", dst_sat_out, 0);
    cyc();
    chk("pt_drained", dst_valid_out, 0);

    send("neg_trunc", -114688, 1'b0, -4, 1'b0);
    send("neg_round", -114688, 1'b1, -3, 1'b0);
    send("neg_tie", -81920, 1'b1, -2, 1'b0);
    chk("sticky_pre", sat_sticky, 0);
    send("sat_pos", longint'(40000) <<< FB, 1'b0, 32767, 1'b1);
    chk("sticky_up", sat_sticky, 1);
    send("sat_neg", -(longint'(40000) <<< FB), 1'b0, -32768, 1'b1);
    sat_clr = 1'b1;
    cyc();
    sat_clr = 1'b0;
    chk("sticky_cleared", sat_sticky, 0);

    // Clear coincides with the clip loading stage 2.
    src_data_in = IW'(longint'(40000) <<< FB); round_en = 1'b0; src_valid_in = 1'b1;
    cyc();
    src_valid_in = 1'b0; sat_clr = 1'b1;
    cyc();
    sat_clr = 1'b0;
    chk("sticky_set_wins", sat_sticky, 1);
    cyc();
    sat_clr = 1'b1;
    cyc();
    sat_clr = 1'b0;

    // Backpressure stream 1..6.
    got.delete();
    i = 0; c = 0;
    while (i < 6 && c < 100) begin
      dst_ready_in = pat[c % 6];
      src_valid_in = 1'b1;
      src_data_in  = IW'(longint'(i + 1) <<< FB);
      #1;
      acc = src_ready_out;
      cyc();
      if (acc) i++;
      c++;
    end
    src_valid_in = 1'b0;
    while (got.size() < 6 && c < 200) begin
      dst_ready_in = pat[c % 6];
      cyc();
      c++;
    end
    dst_ready_in = 1'b1;
    chk("bp_count", got.size(), 6);
    for (int k = 0; k < 6; k++) chk("bp_order", (k < got.size()) ? got[k] : -1, k + 1);

    // Reset with both stages full and the sticky bit set.
    cyc();
    dst_ready_in = 1'b0; src_valid_in = 1'b1; round_en = 1'b0;
    src_data_in = IW'(longint'(40000) <<< FB);
    cyc();
    src_data_in = IW'(longint'(5) <<< FB);
    cyc();
    cyc();
    chk("full_ready", src_ready_out, 0);
    chk("full_sticky", sat_sticky, 1);
    arst_n = 1'b0; src_valid_in = 1'b0;
    cyc();
    arst_n = 1'b1;
    chk("mid_rst_valid", dst_valid_out, 0);
    chk("mid_rst_data", longint'(dst_data_out), 0);
    chk("mid_rst_sticky", sat_sticky, 0);
    send("post_rst", longint'(7) <<< FB, 1'b0, 7, 1'b0);

`ifdef INTERP_REQUANT_SAT_CNT_EN
    for (int k = 0; k < 4; k++) send("cnt_clip", longint'(40000 + k) <<< FB, 1'b0, 32767, 1'b1);
    dst_ready_in = 1'b0; src_valid_in = 1'b1;
    src_data_in = IW'(-(longint'(50000) <<< FB));
    cyc();
    src_valid_in = 1'b0;
    repeat (3) cyc();
    chk("cnt_stalled", sat_count, 4);
    dst_ready_in = 1'b1;
    cyc();
    chk("cnt_five", sat_count, 5);
    sat_clr = 1'b1;
    cyc();
    sat_clr = 1'b0;
    chk("cnt_clear", sat_count, 0);
`endif

    // Randomized traffic with random backpressure and rounding.
    sat_clr = 1'b1;
    cyc();
    sat_clr = 1'b0;
    clip_acc = 1'b0; clip_out = 1'b0; stk_chk = 1'b1;
    for (int n = 0; n < 800; n++) begin
      src_valid_in = ($urandom % 4) != 0;
      dst_ready_in = ($urandom % 3) != 0;
      round_en     = $urandom % 2;
      case ($urandom % 4)
        0:       v = longint'($urandom_range(0, 2000000)) - 1000000;
        1:       v = (longint'($urandom_range(0, 80)) - 40) * ONE + HALF;
        2:       v = longint'($signed(IW'({$urandom, $urandom})));
        default: begin
          v = (longint'(32767) + longint'($urandom_range(0, 4)) - 2) * ONE
            + longint'($urandom_range(0, 32767));
          if ($urandom % 2) v = -v;
        end
      endcase
      src_data_in = IW'(v);
      cyc();
    end
    src_valid_in = 1'b0; dst_ready_in = 1'b1;
    repeat (4) cyc();
    stk_chk = 1'b0;
    chk("rand_drained", exp_d.size(), 0);
    chk("rand_valid_idle", dst_valid_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
